// File: rtl/letc_core_pkg.sv
// Shared LIMP types, FSM encoding and byte-lane helpers for the letc core memory-side blocks.
package letc_core_pkg;

    typedef enum logic [1:0] {
        LIMP_BYTE = 2'b00,
        LIMP_HALF = 2'b01,
        LIMP_WORD = 2'b10,
        LIMP_RSVD = 2'b11
    } limp_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND
    } limp_mem_state_e;

    localparam int LIMP_WAIT_CNT_W = 4;

    function automatic logic [3:0] limp_byte_en(input limp_size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            LIMP_BYTE: be = 4'b0001 << lane;
            LIMP_HALF: be = 4'b0011 << lane;
            LIMP_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] limp_lane_place(input logic [31:0] data, input logic [1:0] lane);
        return data << {lane, 3'b000};
    endfunction

    // Shift the addressed lane down to bit 0 and zero-extend to the access size.
    function automatic logic [31:0] limp_lane_extract(input logic [31:0] word, input limp_size_e size,
                                                      input logic [1:0] lane);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            LIMP_BYTE: result = {24'h0, shifted[7:0]};
            LIMP_HALF: result = {16'h0, shifted[15:0]};
            default:   result = shifted;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/letc_core_limp_if.sv
// LIMP request/response bundle between a core cache (requestor) and a memory (servicer).
interface letc_core_limp_if;
    logic        valid;
    logic        ready;
    logic        wen_nren;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        illegal;

    modport requestor (output valid, wen_nren, size, addr, wdata, input ready, rdata, illegal);
    modport servicer  (input valid, wen_nren, size, addr, wdata, output ready, rdata, illegal);
endinterface

// File: rtl/letc_core_limp_mem_ram.sv
// Single-port word RAM: combinational read of the index, synchronous byte-enabled write.
module letc_core_limp_mem_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             i_clk,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    assign o_rdata = mem[i_idx];

    // NOTE: the array has no reset branch so it maps onto RAM macros; contents start undefined.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/letc_core_limp_mem.sv
// LIMP servicer backed by an internal word RAM, with a fixed number of wait states per access.
module letc_core_limp_mem
    import letc_core_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    letc_core_limp_if.servicer limp
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

    limp_mem_state_e             state_q, state_d;
    logic [LIMP_WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                        wen_q, wen_d;
    limp_size_e                  size_q, size_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;

    logic [31:0] offset;
    logic        req_illegal;
    logic        respond;
    logic [31:0] ram_rdata;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (limp.valid) begin
                    wen_d   = limp.wen_nren;
                    size_d  = limp_size_e'(limp.size);
                    addr_d  = limp.addr;
                    wdata_d = limp.wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = LIMP_WAIT_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // Whatever the requestor presents during the response cycle is not a new request.
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            size_q  <= LIMP_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Addresses below BASE_ADDR wrap to large offsets and fail the range compare.
    assign offset = addr_q - BASE_ADDR;

    always_comb begin
        case (size_q)
            LIMP_HALF: req_illegal = addr_q[0];
            LIMP_WORD: req_illegal = (addr_q[1:0] != 2'b00);
            LIMP_RSVD: req_illegal = 1'b1;
            default:   req_illegal = 1'b0;
        endcase
        if (offset >= MEM_BYTES) begin
            req_illegal = 1'b1;
        end
    end

    assign respond = (state_q == ST_RESPOND);

    letc_core_limp_mem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .i_clk   (i_clk),
        .i_idx   (offset[IDX_W+1:2]),
        .i_we    (respond && wen_q && !req_illegal),
        .i_be    (limp_byte_en(size_q, addr_q[1:0])),
        .i_wdata (limp_lane_place(wdata_q, addr_q[1:0])),
        .o_rdata (ram_rdata)
    );

    assign limp.ready   = respond;
    assign limp.illegal = respond && req_illegal;
    assign limp.rdata   = (respond && !req_illegal && !wen_q)
                          ? limp_lane_extract(ram_rdata, size_q, addr_q[1:0]) : '0;

    assert property (@(posedge i_clk) disable iff (i_rst) (state_q == ST_WAIT) |-> limp.valid);
endmodule
